pipeline_foreground_fetch: RTL and testbench

- Sits directly upstream of the compositing pipeline's foreground inputs.
- Consumes the per-pixel foreground request coordinates and active flag from the pipeline.
- Reads the foreground frame from single-port external SRAM and returns fg_pixel/fg_pixel_skip exactly FETCH_DELAY cycles after each request.
- Opportunistically grants SRAM write slots to a frame loader when no read is in flight.

---
 rtl/pipeline_foreground_fetch_pkg.sv | 22 ++
 rtl/pipeline_delay_line.sv | 35 +++
 rtl/pipeline_foreground_fetch.sv | 144 ++++++++++++++
 tb/tb_pipeline_foreground_fetch.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_foreground_fetch_pkg.sv
// Shared defaults for the foreground fetch block and the compositing pipeline,
// so request-to-result delays and frame geometry stay in one place.
package pipeline_foreground_fetch_pkg;

  localparam int unsigned DefPixelSize   = 16;
  localparam int unsigned DefPrecision   = 11;
  localparam int unsigned DefFgWidth     = 800;
  localparam int unsigned DefFgHeight    = 600;
  localparam int unsigned DefAddrWidth   = 19;
  localparam int unsigned DefFetchDelay  = 4;

  // External SRAM timing: address-to-data cycles.
  localparam int unsigned SramReadLatency = 2;

  // Operation launched on the SRAM port at the next edge.
  typedef enum logic [1:0] {
    PortIdle,
    PortRead,
    PortWrite
  } port_op_e;

endpackage

// File: rtl/pipeline_delay_line.sv
// Fixed-depth shift register with asynchronous active-low clear.
// DEPTH of zero degenerates to a wire.
module pipeline_delay_line #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (DEPTH == 0) begin : g_pass
    assign q_o = d_i;
  end else begin : g_shift
    logic [WIDTH-1:0] stage_q [DEPTH];

    // Shift one stage per cycle; reset clears every stage.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) begin
          stage_q[i] <= '0;
        end
      end else begin
        stage_q[0] <= d_i;
        for (int i = 1; i < DEPTH; i++) begin
          stage_q[i] <= stage_q[i-1];
        end
      end
    end

    assign q_o = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/pipeline_foreground_fetch.sv
// Foreground pixel fetch: maps pipeline request coordinates to SRAM reads and
// returns the pixel a fixed number of cycles later. Loader writes take idle slots.
module pipeline_foreground_fetch
  import pipeline_foreground_fetch_pkg::*;
#(
  parameter int unsigned PIXEL_SIZE        = DefPixelSize,
  parameter int unsigned PRECISION         = DefPrecision,
  parameter int unsigned FG_WIDTH          = DefFgWidth,
  parameter int unsigned FG_HEIGHT         = DefFgHeight,
  parameter int unsigned ADDR_WIDTH        = DefAddrWidth,
  parameter int unsigned SRAM_READ_LATENCY = SramReadLatency,
  parameter int unsigned FETCH_DELAY       = DefFetchDelay
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic signed [PRECISION:0] req_x_i,
  input  logic signed [PRECISION:0] req_y_i,
  input  logic                  req_active_i,
  output logic [PIXEL_SIZE-1:0] fg_pixel_o,
  output logic                  fg_pixel_skip_o,
  input  logic                  wr_valid_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [PIXEL_SIZE-1:0] wr_data_i,
  output logic                  wr_ready_o,
  output logic [ADDR_WIDTH-1:0] sram_addr_o,
  output logic                  sram_oe_n_o,
  output logic                  sram_we_n_o,
  output logic [PIXEL_SIZE-1:0] sram_dq_out_o,
  output logic                  sram_dq_oe_o,
  input  logic [PIXEL_SIZE-1:0] sram_rdata_i
);

  localparam logic [PRECISION-1:0] FgWidthC  = PRECISION'(FG_WIDTH);
  localparam logic [PRECISION-1:0] FgHeightC = PRECISION'(FG_HEIGHT);

  logic                  s1_hit_d, s1_hit_q;
  logic [ADDR_WIDTH-1:0] s1_addr_d, s1_addr_q;
  logic                  x_in, y_in;

  // Range check on the signed coordinates; the address is only formed for hits.
  always_comb begin
    x_in      = !req_x_i[PRECISION] && (req_x_i[PRECISION-1:0] < FgWidthC);
    y_in      = !req_y_i[PRECISION] && (req_y_i[PRECISION-1:0] < FgHeightC);
    s1_hit_d  = req_active_i && x_in && y_in;
    s1_addr_d = '0;
    if (s1_hit_d) begin
      s1_addr_d = ADDR_WIDTH'(req_y_i[PRECISION-1:0]) * ADDR_WIDTH'(FG_WIDTH)
                + ADDR_WIDTH'(req_x_i[PRECISION-1:0]);
    end
  end

  // Stage S1: registered hit flag and linear address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_hit_q  <= 1'b0;
      s1_addr_q <= '0;
    end else begin
      s1_hit_q  <= s1_hit_d;
      s1_addr_q <= s1_addr_d;
    end
  end

  port_op_e port_op;

  // A read on the port now blocks writes for one cycle (bus turnaround).
  always_comb begin
    wr_ready_o = rst_n && !s1_hit_q && sram_oe_n_o;
    port_op    = PortIdle;
    if (s1_hit_q) begin
      port_op = PortRead;
    end else if (wr_valid_i && wr_ready_o) begin
      port_op = PortWrite;
    end
  end

  // SRAM port register: reads win over writes, writes over idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sram_addr_o   <= '0;
      sram_oe_n_o   <= 1'b1;
      sram_we_n_o   <= 1'b1;
      sram_dq_out_o <= '0;
      sram_dq_oe_o  <= 1'b0;
    end else begin
      unique case (port_op)
        PortRead: begin
          sram_addr_o  <= s1_addr_q;
          sram_oe_n_o  <= 1'b0;
          sram_we_n_o  <= 1'b1;
          sram_dq_oe_o <= 1'b0;
        end
        PortWrite: begin
          sram_addr_o   <= wr_addr_i;
          sram_dq_out_o <= wr_data_i;
          sram_oe_n_o   <= 1'b1;
          sram_we_n_o   <= 1'b0;
          sram_dq_oe_o  <= 1'b1;
        end
        default: begin
          sram_oe_n_o  <= 1'b1;
          sram_we_n_o  <= 1'b1;
          sram_dq_oe_o <= 1'b0;
        end
      endcase
    end
  end

  logic                  hit_aligned;
  logic [PIXEL_SIZE-1:0] data_aligned;

  // Hit flag follows the request so it lines up with the captured read data.
  pipeline_delay_line #(
    .WIDTH (1),
    .DEPTH (FETCH_DELAY - 1)
  ) u_hit_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (s1_hit_q),
    .q_o   (hit_aligned)
  );

  // First stage samples rdata when it becomes valid; the rest pads to FETCH_DELAY.
  pipeline_delay_line #(
    .WIDTH (PIXEL_SIZE),
    .DEPTH (FETCH_DELAY - 1 - SRAM_READ_LATENCY)
  ) u_data_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (sram_rdata_i),
    .q_o   (data_aligned)
  );

  // Output register: pixel on hit, skip with zeroed pixel otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fg_pixel_o      <= '0;
      fg_pixel_skip_o <= 1'b1;
    end else begin
      fg_pixel_skip_o <= !hit_aligned;
      fg_pixel_o      <= hit_aligned ? data_aligned : '0;
    end
  end

endmodule

// File: tb/tb_pipeline_foreground_fetch.sv
// Bench for pipeline_foreground_fetch: SRAM model plus a coordinate-level reference.
module tb_pipeline_foreground_fetch;

  localparam int PS   = 16;
  localparam int PREC = 11;
  localparam int FW   = 800;
  localparam int FH   = 600;
  localparam int AW   = 19;

  logic                   clk;
  logic                   rst_n;
  logic signed [PREC:0]   req_x, req_y;
  logic                   req_active;
  logic [PS-1:0]          fg_pixel;
  logic                   fg_pixel_skip;
  logic                   wr_valid;
  logic [AW-1:0]          wr_addr;
  logic [PS-1:0]          wr_data;
  logic                   wr_ready;
  logic [AW-1:0]          sram_addr;
  logic                   sram_oe_n, sram_we_n, sram_dq_oe;
  logic [PS-1:0]          sram_dq_out, sram_rdata, rd_s1;

  int total = 0;
  int bad   = 0;

  logic [PS-1:0] mem     [0:(1<<AW)-1];
  logic [PS-1:0] ref_mem [0:(1<<AW)-1];

  int px [256];
  int py [256];
  bit pa [256];
  logic [PS-1:0] obs_pix   [262];
  logic          obs_skip  [262];
  logic          obs_oe_n  [262];
  logic [AW-1:0] obs_addr  [262];

  pipeline_foreground_fetch dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_x_i         (req_x),
    .req_y_i         (req_y),
    .req_active_i    (req_active),
    .fg_pixel_o      (fg_pixel),
    .fg_pixel_skip_o (fg_pixel_skip),
    .wr_valid_i      (wr_valid),
    .wr_addr_i       (wr_addr),
    .wr_data_i       (wr_data),
    .wr_ready_o      (wr_ready),
    .sram_addr_o     (sram_addr),
    .sram_oe_n_o     (sram_oe_n),
    .sram_we_n_o     (sram_we_n),
    .sram_dq_out_o   (sram_dq_out),
    .sram_dq_oe_o    (sram_dq_oe),
    .sram_rdata_i    (sram_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // SRAM model: data for an address registered at edge k+1 is stable before edge k+3.
  always @(negedge clk) begin
    if (!sram_we_n && sram_dq_oe) mem[sram_addr] <= sram_dq_out;
    rd_s1      <= !sram_oe_n ? mem[sram_addr] : 16'h0BAD;
    sram_rdata <= rd_s1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit ref_hit(int x, int y, bit a);
    return a && x >= 0 && x < FW && y >= 0 && y < FH;
  endfunction

  // Drives n requests then 6 idle slots, recording outputs before each drive.
  // Request i: SRAM address visible at slot i+2, result at slot i+5.
  task automatic play(input int n);
    for (int j = 0; j < n + 6; j++) begin
      @(negedge clk);
      obs_pix[j]  = fg_pixel;
      obs_skip[j] = fg_pixel_skip;
      obs_oe_n[j] = sram_oe_n;
      obs_addr[j] = sram_addr;
      if (j < n) begin
        req_x      = px[j][PREC:0];
        req_y      = py[j][PREC:0];
        req_active = pa[j];
      end else begin
        req_active = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wr_valid = 1'b1;
    req_active = 1'b1;
    req_x = 12'sd3;
    req_y = 12'sd3;
    repeat (3) @(negedge clk);
    total++; if (fg_pixel_skip !== 1'b1) begin bad++;
      $display("FAIL reset_skip: got %b expected 1", fg_pixel_skip); end
    total++; if (fg_pixel !== '0) begin bad++;
      $display("FAIL reset_pixel: got %h expected 0", fg_pixel); end
    total++; if (sram_oe_n !== 1'b1 || sram_we_n !== 1'b1) begin bad++;
      $display("FAIL reset_enables: got oe_n=%b we_n=%b expected 1 1", sram_oe_n, sram_we_n); end
    total++; if (sram_dq_oe !== 1'b0 || sram_dq_out !== '0 || sram_addr !== '0) begin bad++;
      $display("FAIL reset_bus: got dq_oe=%b dq=%h addr=%0d expected 0 0 0",
               sram_dq_oe, sram_dq_out, sram_addr); end
    total++; if (wr_ready !== 1'b0) begin bad++;
      $display("FAIL reset_wr_ready: got %b expected 0", wr_ready); end
    wr_valid = 1'b0;
    req_active = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_read_hit();
    px[0] = 10; py[0] = 2; pa[0] = 1'b1;
    play(1);
    total++; if (obs_oe_n[2] !== 1'b0 || obs_addr[2] !== 19'd1610) begin bad++;
      $display("FAIL read_hit_addr: got oe_n=%b addr=%0d expected oe_n=0 addr=1610",
               obs_oe_n[2], obs_addr[2]); end
    total++; if (obs_skip[5] !== 1'b0 || obs_pix[5] !== 16'hABCD) begin bad++;
      $display("FAIL read_hit_data: got skip=%b pix=%h expected skip=0 pix=abcd",
               obs_skip[5], obs_pix[5]); end
  endtask

  task automatic test_misses();
    int lows;
    px[0] = -1;  py[0] = 0;   pa[0] = 1'b1;
    px[1] = 800; py[1] = 0;   pa[1] = 1'b1;
    px[2] = 0;   py[2] = 600; pa[2] = 1'b1;
    px[3] = 5;   py[3] = 5;   pa[3] = 1'b0;
    play(4);
    for (int i = 0; i < 4; i++) begin
      total++; if (obs_skip[i+5] !== 1'b1 || obs_pix[i+5] !== '0) begin bad++;
        $display("FAIL miss_%0d: got skip=%b pix=%h expected skip=1 pix=0",
                 i, obs_skip[i+5], obs_pix[i+5]); end
    end
    lows = 0;
    for (int j = 0; j < 10; j++) if (obs_oe_n[j] !== 1'b1) lows++;
    total++; if (lows != 0) begin bad++;
      $display("FAIL miss_no_read: got %0d read cycles expected 0", lows); end
  endtask

  task automatic test_corner_stream();
    int a;
    for (int i = 0; i < 8; i++) begin
      px[i] = 792 + i; py[i] = 599; pa[i] = 1'b1;
    end
    play(8);
    for (int i = 0; i < 8; i++) begin
      a = 479992 + i;
      total++; if (obs_oe_n[i+2] !== 1'b0 || obs_addr[i+2] !== AW'(a)) begin bad++;
        $display("FAIL stream_addr_%0d: got oe_n=%b addr=%0d expected oe_n=0 addr=%0d",
                 i, obs_oe_n[i+2], obs_addr[i+2], a); end
      total++; if (obs_skip[i+5] !== 1'b0 || obs_pix[i+5] !== ref_mem[a]) begin bad++;
        $display("FAIL stream_data_%0d: got skip=%b pix=%h expected skip=0 pix=%h",
                 i, obs_skip[i+5], obs_pix[i+5], ref_mem[a]); end
    end
  endtask

  task automatic test_random();
    int n, a;
    bit h;
    n = 200;
    for (int i = 0; i < n; i++) begin
      px[i] = int'($urandom_range(0, 840)) - 20;
      py[i] = int'($urandom_range(0, 640)) - 20;
      pa[i] = ($urandom_range(0, 3) != 0);
    end
    play(n);
    for (int i = 0; i < n; i++) begin
      h = ref_hit(px[i], py[i], pa[i]);
      a = h ? py[i] * FW + px[i] : 0;
      if (h) begin
        total++; if (obs_oe_n[i+2] !== 1'b0 || obs_addr[i+2] !== AW'(a)) begin bad++;
          $display("FAIL rand_addr_%0d (%0d,%0d): got oe_n=%b addr=%0d expected oe_n=0 addr=%0d",
                   i, px[i], py[i], obs_oe_n[i+2], obs_addr[i+2], a); end
        total++; if (obs_skip[i+5] !== 1'b0 || obs_pix[i+5] !== ref_mem[a]) begin bad++;
          $display("FAIL rand_data_%0d: got skip=%b pix=%h expected skip=0 pix=%h",
                   i, obs_skip[i+5], obs_pix[i+5], ref_mem[a]); end
      end else begin
        total++; if (obs_oe_n[i+2] !== 1'b1) begin bad++;
          $display("FAIL rand_noread_%0d (%0d,%0d,%b): got oe_n=%b expected 1",
                   i, px[i], py[i], pa[i], obs_oe_n[i+2]); end
        total++; if (obs_skip[i+5] !== 1'b1 || obs_pix[i+5] !== '0) begin bad++;
          $display("FAIL rand_miss_%0d: got skip=%b pix=%h expected skip=1 pix=0",
                   i, obs_skip[i+5], obs_pix[i+5]); end
      end
    end
  endtask

  task automatic test_write_blank();
    @(negedge clk);
    wr_valid = 1'b1; wr_addr = 19'd100; wr_data = 16'h1234;
    #1;
    total++; if (wr_ready !== 1'b1) begin bad++;
      $display("FAIL wr_blank_ready: got %b expected 1", wr_ready); end
    @(negedge clk);
    total++; if (sram_we_n !== 1'b0 || sram_dq_oe !== 1'b1 || sram_oe_n !== 1'b1 ||
                 sram_addr !== 19'd100 || sram_dq_out !== 16'h1234) begin bad++;
      $display("FAIL wr_blank_cycle: got we_n=%b dq_oe=%b oe_n=%b addr=%0d dq=%h expected 0 1 1 100 1234",
               sram_we_n, sram_dq_oe, sram_oe_n, sram_addr, sram_dq_out); end
    wr_valid = 1'b0;
    @(negedge clk);
    total++; if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0) begin bad++;
      $display("FAIL wr_blank_single: got we_n=%b dq_oe=%b expected 1 0", sram_we_n, sram_dq_oe); end
    ref_mem[100] = 16'h1234;
    px[0] = 100; py[0] = 0; pa[0] = 1'b1;
    play(1);
    total++; if (obs_skip[5] !== 1'b0 || obs_pix[5] !== 16'h1234) begin bad++;
      $display("FAIL wr_blank_readback: got skip=%b pix=%h expected skip=0 pix=1234",
               obs_skip[5], obs_pix[5]); end
  endtask

  task automatic test_contention();
    int starved;
    starved = 0;
    wr_valid = 1'b0; wr_addr = 19'd200; wr_data = 16'h5A5A;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 1) wr_valid = 1'b1;
      req_x = 12'(i); req_y = 12'sd1; req_active = 1'b1;
      #1;
      if (i >= 1 && (wr_ready !== 1'b0 || sram_we_n !== 1'b1)) starved++;
    end
    total++; if (starved != 0) begin bad++;
      $display("FAIL cont_starve: got %0d cycles with write allowed expected 0", starved); end
    @(negedge clk);
    req_active = 1'b0;
    #1;
    total++; if (wr_ready !== 1'b0) begin bad++;
      $display("FAIL cont_last_hit: got wr_ready=%b expected 0", wr_ready); end
    @(negedge clk); #1;
    total++; if (wr_ready !== 1'b0 || sram_oe_n !== 1'b0) begin bad++;
      $display("FAIL cont_turnaround: got wr_ready=%b oe_n=%b expected 0 0", wr_ready, sram_oe_n); end
    @(negedge clk); #1;
    total++; if (wr_ready !== 1'b1 || sram_we_n !== 1'b1) begin bad++;
      $display("FAIL cont_ready: got wr_ready=%b we_n=%b expected 1 1", wr_ready, sram_we_n); end
    @(negedge clk);
    total++; if (sram_we_n !== 1'b0 || sram_dq_oe !== 1'b1 || sram_addr !== 19'd200) begin bad++;
      $display("FAIL cont_write: got we_n=%b dq_oe=%b addr=%0d expected 0 1 200",
               sram_we_n, sram_dq_oe, sram_addr); end
    wr_valid = 1'b0;
    ref_mem[200] = 16'h5A5A;
    px[0] = 200; py[0] = 0; pa[0] = 1'b1;
    play(1);
    total++; if (obs_skip[5] !== 1'b0 || obs_pix[5] !== 16'h5A5A) begin bad++;
      $display("FAIL cont_readback: got skip=%b pix=%h expected skip=0 pix=5a5a",
               obs_skip[5], obs_pix[5]); end
  endtask

  task automatic test_reset_midstream();
    int early;
    int a;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req_x = 12'(20 + i); req_y = 12'sd3; req_active = 1'b1;
    end
    @(negedge clk);
    req_active = 1'b0;
    rst_n = 1'b0;
    #1;
    total++; if (fg_pixel_skip !== 1'b1 || fg_pixel !== '0 || sram_oe_n !== 1'b1 ||
                 sram_we_n !== 1'b1 || wr_ready !== 1'b0) begin bad++;
      $display("FAIL midreset_state: got skip=%b pix=%h oe_n=%b we_n=%b wr_ready=%b expected 1 0 1 1 0",
               fg_pixel_skip, fg_pixel, sram_oe_n, sram_we_n, wr_ready); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    px[0] = 30; py[0] = 4; pa[0] = 1'b1;
    play(1);
    early = 0;
    for (int j = 0; j < 5; j++) if (obs_skip[j] !== 1'b1) early++;
    total++; if (early != 0) begin bad++;
      $display("FAIL midreset_flush: got %0d stale outputs expected 0", early); end
    a = 4 * FW + 30;
    total++; if (obs_skip[5] !== 1'b0 || obs_pix[5] !== ref_mem[a]) begin bad++;
      $display("FAIL midreset_first: got skip=%b pix=%h expected skip=0 pix=%h",
               obs_skip[5], obs_pix[5], ref_mem[a]); end
  endtask

  initial begin
    rst_n = 1'b0;
    req_x = '0; req_y = '0; req_active = 1'b0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    for (int i = 0; i < FW * FH; i++) begin
      mem[i] = 16'($urandom);
      ref_mem[i] = mem[i];
    end
    mem[1610] = 16'hABCD;
    ref_mem[1610] = 16'hABCD;

    test_reset();
    test_read_hit();
    test_misses();
    test_corner_stream();
    test_write_blank();
    test_contention();
    test_random();
    test_reset_midstream();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
